// File: rtl/note_spawner_pkg.sv
// Shared definitions for the note spawner: lane position codes, lane state
// encodings, retire timing, LFSR feedback and counter sizing helper.
package note_spawner_pkg;

   // Lane position codes driven to the judge/display
   localparam logic [3:0] POS_IDLE   = 4'd0;
   localparam logic [3:0] POS_RETIRE = 4'd11;
   localparam logic [3:0] CELL_MIN   = 4'd1;
   localparam logic [3:0] CELL_MAX   = 4'd9;

   // Lane state encodings
   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_SPAWN_WAIT = 2'd1;
   localparam logic [1:0] ST_ACTIVE     = 2'd2;
   localparam logic [1:0] ST_RETIRE     = 2'd3;

   // Clocks the retire marker stays on the bus so the judge can drop its flag
   localparam int unsigned RETIRE_CLKS = 2;

   // Galois feedback mask for x^8 + x^6 + x^5 + x^4 + 1 (right-shifting form)
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   // Width for life/gap counters: must hold max(LIFE, GAP+2)
   function automatic int unsigned ctr_width(input int unsigned life, input int unsigned gap);
      int unsigned m;
      m = (life > gap + 2) ? life : gap + 2;
      return $clog2(m + 1);
   endfunction

   // One LFSR step; a nonzero state never maps to zero
   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {1'b0, s[7:1]} ^ (s[0] ? LFSR_TAPS : 8'h00);
   endfunction

endpackage

// File: rtl/note_spawner_lane.sv
// One target lane: IDLE -> SPAWN_WAIT -> ACTIVE -> RETIRE -> IDLE, with its
// gap/life/retire counters and the registered position output.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   run_i          game running
//   run_rise_i     first clk of run after it was low (reload stagger)
//   step_i         one-clk game tick
//   hit_i          sticky hit flag from the judge for this lane
//   grant_i        spawn grant from the arbiter
//   cell_i         cell to show when granted (1..9)
//   pos_o          registered lane position (0, 1..9, 11)
//   active_o       registered: lane is showing a cell
//   req_c_o        lane is waiting for a spawn grant
//   hit_c_o        pulse: target scored this clk
//   miss_c_o       pulse: target expired this clk
module note_spawner_lane
   import note_spawner_pkg::*;
#(
   parameter int unsigned LIFE     = 8,
   parameter int unsigned GAP      = 3,
   parameter int unsigned LANE_IDX = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run_i,
   input  logic       run_rise_i,
   input  logic       step_i,
   input  logic       hit_i,
   input  logic       grant_i,
   input  logic [3:0] cell_i,
   output logic [3:0] pos_o,
   output logic       active_o,
   output logic       req_c_o,
   output logic       hit_c_o,
   output logic       miss_c_o
);

   localparam int unsigned CW = ctr_width(LIFE, GAP);

   logic [1:0]    state_q, state_d;
   logic [3:0]    pos_q, pos_d;
   logic          active_q, active_d;
   logic [CW-1:0] life_q, life_d;
   logic [CW-1:0] gap_q, gap_d;
   logic          ret_q, ret_d;
   logic          retire_c;

   // State and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         pos_q    <= POS_IDLE;
         active_q <= 1'b0;
         life_q   <= '0;
         gap_q    <= CW'(GAP + LANE_IDX);
         ret_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         active_q <= active_d;
         life_q   <= life_d;
         gap_q    <= gap_d;
         ret_q    <= ret_d;
      end
   end

   // Next-state, counters and event pulses
   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      active_d = active_q;
      life_d   = life_q;
      gap_d    = gap_q;
      ret_d    = ret_q;
      retire_c = 1'b0;
      hit_c_o  = 1'b0;
      miss_c_o = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Rise clk only reloads the stagger; counting starts next clk
            if (run_i && !run_rise_i) begin
               if (gap_q == '0) begin
                  state_d = ST_SPAWN_WAIT;
               end else if (step_i) begin
                  gap_d = gap_q - CW'(1);
               end
            end
         end
         ST_SPAWN_WAIT: begin
            if (!run_i) begin
               state_d = ST_IDLE;
            end else if (grant_i) begin
               state_d  = ST_ACTIVE;
               pos_d    = cell_i;
               active_d = 1'b1;
               life_d   = CW'(LIFE);
            end
         end
         ST_ACTIVE: begin
            // Hit takes precedence over a coinciding expiry
            if (!run_i) begin
               retire_c = 1'b1;
            end else if (hit_i) begin
               hit_c_o  = 1'b1;
               retire_c = 1'b1;
            end else if (step_i) begin
               if (life_q <= CW'(1)) begin
                  miss_c_o = 1'b1;
                  retire_c = 1'b1;
               end else begin
                  life_d = life_q - CW'(1);
               end
            end
            if (retire_c) begin
               state_d  = ST_RETIRE;
               pos_d    = POS_RETIRE;
               active_d = 1'b0;
               ret_d    = 1'(RETIRE_CLKS - 1);
            end
         end
         ST_RETIRE: begin
            if (ret_q == 1'b0) begin
               state_d = ST_IDLE;
               pos_d   = POS_IDLE;
               gap_d   = CW'(GAP);
            end else begin
               ret_d = ret_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (run_rise_i) begin
         gap_d = CW'(GAP + LANE_IDX);
      end
   end

   assign pos_o    = pos_q;
   assign active_o = active_q;
   assign req_c_o  = (state_q == ST_SPAWN_WAIT);

endmodule

// File: rtl/note_spawner.sv
// Producer side of the hit-judge interface: game tick prescaler, LFSR cell
// picker, spawn arbiter over three lanes, saturating score/miss tallies.
// Ports:
//   clk, rst             clock, async active-low reset
//   run                  game running; low freezes and clears the board
//   hit_0..hit_2         sticky hit flags from the judge
//   pos_0..pos_2         lane position: 0 idle, 1..9 cell, 11 retire marker
//   lane_active          bit i set while lane i shows a cell
//   score, misses        saturating hit/expiry tallies
module note_spawner
   import note_spawner_pkg::*;
#(
   parameter int unsigned TICK_DIV = 25_000_000,
   parameter int unsigned LIFE     = 8,
   parameter int unsigned GAP      = 3,
   parameter logic [7:0]  SEED     = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       hit_0,
   input  logic       hit_1,
   input  logic       hit_2,
   output logic [3:0] pos_0,
   output logic [3:0] pos_1,
   output logic [3:0] pos_2,
   output logic [2:0] lane_active,
   output logic [7:0] score,
   output logic [7:0] misses
);

   localparam int unsigned PW = $clog2(TICK_DIV + 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    lfsr_q, lfsr_d;
   logic          run_q;
   logic [7:0]    score_q, score_d;
   logic [7:0]    miss_q, miss_d;

   logic          step_c;
   logic          run_rise_c;
   logic [3:0]    cand_c;
   logic [3:0]    cell_c;
   logic          cell_ok_c;
   logic          occupied_c;
   logic [2:0]    hit_in_c;
   logic [2:0]    req_c, grant_c, hit_evt_c, miss_evt_c;
   logic [2:0]    active_w;
   logic [3:0]    pos_w [3];
   logic [1:0]    n_hit_c, n_miss_c;
   logic [9:0]    score_sum_c, miss_sum_c;

   assign step_c     = run && (presc_q == PW'(TICK_DIV - 1));
   assign run_rise_c = run && !run_q;
   assign hit_in_c   = {hit_2, hit_1, hit_0};

   // Candidate cell from the low nibble; nibble 9..15 means retry next clk
   assign cand_c     = lfsr_q[3:0];
   assign cell_ok_c  = (cand_c <= (CELL_MAX - CELL_MIN));
   assign cell_c     = cand_c + CELL_MIN;
   assign occupied_c = (pos_w[0] == cell_c) || (pos_w[1] == cell_c) || (pos_w[2] == cell_c);

   // Fixed-priority arbiter, at most one spawn per clk
   always_comb begin
      grant_c = 3'b000;
      if (run && cell_ok_c && !occupied_c) begin
         if (req_c[0]) begin
            grant_c = 3'b001;
         end else if (req_c[1]) begin
            grant_c = 3'b010;
         end else if (req_c[2]) begin
            grant_c = 3'b100;
         end
      end
   end

   for (genvar i = 0; i < 3; i++) begin : g_lane
      note_spawner_lane #(
         .LIFE     (LIFE),
         .GAP      (GAP),
         .LANE_IDX (i)
      ) u_lane (
         .clk        (clk),
         .rst_n      (rst),
         .run_i      (run),
         .run_rise_i (run_rise_c),
         .step_i     (step_c),
         .hit_i      (hit_in_c[i]),
         .grant_i    (grant_c[i]),
         .cell_i     (cell_c),
         .pos_o      (pos_w[i]),
         .active_o   (active_w[i]),
         .req_c_o    (req_c[i]),
         .hit_c_o    (hit_evt_c[i]),
         .miss_c_o   (miss_evt_c[i])
      );
   end

   // Several lanes may score or expire on the same clk
   assign n_hit_c     = 2'(hit_evt_c[0]) + 2'(hit_evt_c[1]) + 2'(hit_evt_c[2]);
   assign n_miss_c    = 2'(miss_evt_c[0]) + 2'(miss_evt_c[1]) + 2'(miss_evt_c[2]);
   assign score_sum_c = 10'(score_q) + 10'(n_hit_c);
   assign miss_sum_c  = 10'(miss_q) + 10'(n_miss_c);

   // Prescaler, LFSR and saturating tallies
   always_comb begin
      presc_d = '0;
      lfsr_d  = lfsr_q;
      score_d = (score_sum_c > 10'd255) ? 8'hFF : score_sum_c[7:0];
      miss_d  = (miss_sum_c > 10'd255) ? 8'hFF : miss_sum_c[7:0];
      if (run) begin
         presc_d = step_c ? '0 : presc_q + PW'(1);
         lfsr_d  = lfsr_next(lfsr_q);
      end
      if (run_rise_c) begin
         score_d = 8'h00;
         miss_d  = 8'h00;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_q <= '0;
         lfsr_q  <= SEED;
         run_q   <= 1'b0;
         score_q <= 8'h00;
         miss_q  <= 8'h00;
      end else begin
         presc_q <= presc_d;
         lfsr_q  <= lfsr_d;
         run_q   <= run;
         score_q <= score_d;
         miss_q  <= miss_d;
      end
   end

   assign pos_0       = pos_w[0];
   assign pos_1       = pos_w[1];
   assign pos_2       = pos_w[2];
   assign lane_active = active_w;
   assign score       = score_q;
   assign misses      = miss_q;

endmodule
